// File: rtl/counter_ctrl.sv
// counter_ctrl: run/pause/step/clear sequencer for the board's 6-bit LED counter.
// Debounces three raw buttons, runs the advance prescaler and drives the
// counter's one-cycle advance (cnt_en) and clear (cnt_clr) strobes.
module counter_ctrl #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_100MHz,
    input  logic rst,
    input  logic btn_run,
    input  logic btn_step,
    input  logic btn_clr,
    output logic cnt_en,
    output logic cnt_clr,
    output logic running,
    output logic heartbeat
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = $clog2(TICK_DIV);
    localparam int DW       = $clog2(DEBOUNCE_CYCLES);
    localparam int NB       = 3;

    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    // Button bit order: 0 = run, 1 = step, 2 = clear.
    logic [NB-1:0] w_btn_raw;
    logic [NB-1:0] r_sync1;
    logic [NB-1:0] r_sync2;
    logic [NB-1:0] r_deb;
    logic [NB-1:0] r_deb_d;
    logic [NB-1:0] r_armed;
    logic [NB-1:0] r_press;
    logic [1:0]    r_fill;
    logic [DW-1:0] r_db_cnt [NB];

    logic [1:0]    r_state;
    logic [PW-1:0] r_pre;
    logic          r_cnt_en;
    logic          r_cnt_clr;
    logic          r_running;
    logic          r_heartbeat;

    logic [1:0]    w_state_nx;
    logic [PW-1:0] w_pre_nx;
    logic          w_en_nx;
    logic          w_clr_nx;
    logic          w_run_p;
    logic          w_step_p;
    logic          w_clr_p;

    assign w_btn_raw = {btn_clr, btn_step, btn_run};
    assign w_run_p   = r_press[0];
    assign w_step_p  = r_press[1];
    assign w_clr_p   = r_press[2];

    // Two-flop synchronizers; r_fill marks when r_sync2 holds real post-reset samples.
    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_fill  <= 2'b00;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_fill  <= {r_fill[0], 1'b1};
        end
    end

    // Debouncers: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            r_deb <= '0;
            for (int i = 0; i < NB; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_MAX) begin
                    r_deb[i]    <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Registered rising-edge detect; a button is armed only once it has been seen released,
    // so a button held through reset stays silent until it is pressed again.
    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            r_deb_d <= '0;
            r_armed <= '0;
            r_press <= '0;
        end else begin
            r_deb_d <= r_deb;
            r_armed <= r_armed | (~r_sync2 & {NB{r_fill[1]}});
            r_press <= r_deb & ~r_deb_d & r_armed;
        end
    end

    // Next-state, prescaler and strobe decode; clear outranks run, run outranks step.
    always_comb begin
        w_state_nx = r_state;
        w_pre_nx   = r_pre;
        w_en_nx    = 1'b0;
        w_clr_nx   = 1'b0;
        if (w_clr_p) begin
            w_clr_nx   = 1'b1;
            w_state_nx = S_IDLE;
            w_pre_nx   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_run_p) begin
                        w_state_nx = S_RUN;
                        w_pre_nx   = '0;
                    end else if (w_step_p) begin
                        w_en_nx    = 1'b1;
                        w_state_nx = S_PAUSE;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
                S_RUN: begin
                    w_pre_nx = (r_pre == PRE_MAX) ? '0 : r_pre + PW'(1);
                    if (w_run_p) begin
                        // Pausing swallows a tick that lands in the same cycle.
                        w_state_nx = S_PAUSE;
                    end else if (r_pre == PRE_MAX) begin
                        w_en_nx = 1'b1;
                    end else begin
                        w_state_nx = S_RUN;
                    end
                end
                S_PAUSE: begin
                    if (w_run_p) begin
                        // Prescaler is kept so the partial period resumes.
                        w_state_nx = S_RUN;
                    end else if (w_step_p) begin
                        w_en_nx = 1'b1;
                    end else begin
                        w_state_nx = S_PAUSE;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_pre_nx   = '0;
                end
            endcase
        end
    end

    // State, prescaler and registered outputs.
    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pre       <= '0;
            r_cnt_en    <= 1'b0;
            r_cnt_clr   <= 1'b0;
            r_running   <= 1'b0;
            r_heartbeat <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pre       <= w_pre_nx;
            r_cnt_en    <= w_en_nx;
            r_cnt_clr   <= w_clr_nx;
            r_running   <= (w_state_nx == S_RUN);
            r_heartbeat <= r_heartbeat ^ w_en_nx;
        end
    end

    assign cnt_en    = r_cnt_en;
    assign cnt_clr   = r_cnt_clr;
    assign running   = r_running;
    assign heartbeat = r_heartbeat;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed self-checking bench for counter_ctrl with
// CLK_HZ=20, TICK_HZ=1 (TICK_DIV=20) and DEBOUNCE_CYCLES=4.
module tb_counter_ctrl;

    logic       clk_100MHz = 1'b0;
    logic       rst;
    logic [2:0] btns;
    logic       cnt_en;
    logic       cnt_clr;
    logic       running;
    logic       heartbeat;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int en_q[$];
    int clr_q[$];
    int rise_q[$];
    int fall_q[$];
    int n_hb = 0;
    int n_wide = 0;
    int n_both = 0;
    logic prev_en = 1'b0;
    logic prev_clr = 1'b0;
    logic prev_run = 1'b0;
    logic prev_hb = 1'b0;

    counter_ctrl #(
        .CLK_HZ         (20),
        .TICK_HZ        (1),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .rst       (rst),
        .btn_run   (btns[0]),
        .btn_step  (btns[1]),
        .btn_clr   (btns[2]),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .running   (running),
        .heartbeat (heartbeat)
    );

    // 10 ns clock
    always #5 clk_100MHz = ~clk_100MHz;

    // Cycle index: number of rising edges seen so far.
    always @(posedge clk_100MHz) cyc <= cyc + 1;

    // Output monitor sampled on the falling edge.
    always @(negedge clk_100MHz) begin
        if (cnt_en) begin
            en_q.push_back(cyc);
            if (prev_en) n_wide++;
        end
        if (cnt_clr) begin
            clr_q.push_back(cyc);
            if (prev_clr) n_wide++;
        end
        if (cnt_en && cnt_clr) n_both++;
        if (running && !prev_run) rise_q.push_back(cyc);
        if (!running && prev_run) fall_q.push_back(cyc);
        if (heartbeat != prev_hb) n_hb++;
        prev_en  = cnt_en;
        prev_clr = cnt_clr;
        prev_run = running;
        prev_hb  = heartbeat;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    // Clean press: hold the selected buttons 10 cycles, then release.
    task automatic press(input logic [2:0] mask);
        btns = mask;
        repeat (10) step();
        btns = 3'b000;
    endtask

    function automatic int en_between(input int lo, input int hi);
        int n = 0;
        foreach (en_q[k]) if (en_q[k] > lo && en_q[k] <= hi) n++;
        return n;
    endfunction

    function automatic int first_en_after(input int lo);
        foreach (en_q[k]) if (en_q[k] > lo) return en_q[k];
        return -1;
    endfunction

    function automatic int q_at(input int q[$], input int k);
        if (k < q.size()) return q[k];
        return -1;
    endfunction

    int r0;

    initial begin
        rst  = 1'b1;
        btns = 3'b000;
        #1 rst = 1'b0;

        // Reset
        repeat (5) step();
        check("reset_outputs", {cnt_en, cnt_clr, running, heartbeat}, 0);
        rst = 1'b1;
        goto(105);
        @(negedge clk_100MHz);
        check("idle_no_en", en_q.size(), 0);
        check("idle_no_clr", clr_q.size(), 0);
        check("idle_no_run", rise_q.size(), 0);
        check("idle_outputs", {cnt_en, cnt_clr, running, heartbeat}, 0);

        // Debounce: three 3-cycle glitches, then a clean 10-cycle press at cycle 140
        goto(110);
        repeat (3) begin
            btns[0] = 1'b1;
            repeat (3) step();
            btns[0] = 1'b0;
            repeat (5) step();
        end
        goto(140);
        press(3'b001);
        r0 = 148;

        // Run rate over 100 cycles after running rises
        goto(r0 + 110);
        @(negedge clk_100MHz);
        check("glitch_run_rise", q_at(rise_q, 0), r0);
        check("single_run_event", rise_q.size(), 1);
        check("run_still_high", running, 1);
        check("run_pulses_100", en_between(r0, r0 + 100), 5);
        check("first_pulse", first_en_after(r0), r0 + 20);
        check("pulse_spacing_40", q_at(en_q, 1), r0 + 40);
        check("pulse_spacing_100", q_at(en_q, 4), r0 + 100);
        check("heartbeat_toggles", n_hb, 5);

        // Pause 7 cycles after the tick at r0+120
        goto(r0 + 119);
        press(3'b001);
        goto(r0 + 140);
        @(negedge clk_100MHz);
        check("pause_fall", q_at(fall_q, 0), r0 + 127);
        check("pause_running", running, 0);

        // Resume 50 cycles later
        goto(r0 + 169);
        press(3'b001);
        goto(r0 + 200);
        @(negedge clk_100MHz);
        check("resume_rise", q_at(rise_q, 1), r0 + 177);
        check("paused_no_en", en_between(r0 + 120, r0 + 177), 0);
        check("resume_first", first_en_after(r0 + 177) - (r0 + 177), 13);

        // Step while running is ignored
        goto(r0 + 200);
        press(3'b010);
        goto(r0 + 235);
        @(negedge clk_100MHz);
        check("run_step_ignored", en_between(r0 + 200, r0 + 235), 2);

        // Pause, then three steps
        goto(r0 + 235);
        press(3'b001);
        goto(r0 + 250);
        press(3'b010);
        goto(r0 + 270);
        press(3'b010);
        goto(r0 + 290);
        press(3'b010);
        goto(r0 + 310);
        @(negedge clk_100MHz);
        check("pause2_fall", q_at(fall_q, 1), r0 + 243);
        check("pause_steps", en_between(r0 + 243, r0 + 310), 3);
        check("step_first", first_en_after(r0 + 243), r0 + 258);
        check("step_stays_paused", running, 0);

        // Resume, then clear and run on the same cycle
        goto(r0 + 310);
        press(3'b001);
        goto(r0 + 330);
        press(3'b101);
        goto(r0 + 350);
        @(negedge clk_100MHz);
        check("resume2_pulse", first_en_after(r0 + 318), r0 + 325);
        check("clr_count", clr_q.size(), 1);
        check("clr_cycle", q_at(clr_q, 0), r0 + 338);
        check("clr_no_en", n_both, 0);
        check("clr_fall", q_at(fall_q, 2), r0 + 338);
        check("clr_running", running, 0);

        // Fresh run after clear gets a full first period
        goto(r0 + 360);
        press(3'b001);
        goto(r0 + 395);
        @(negedge clk_100MHz);
        check("restart_rise", q_at(rise_q, 3), r0 + 368);
        check("restart_first", first_en_after(r0 + 368), r0 + 388);

        // Reset mid-run
        step();
        rst = 1'b0;
        #1;
        check("rst_async", {cnt_en, cnt_clr, running, heartbeat}, 0);
        repeat (5) step();
        rst = 1'b1;
        goto(r0 + 440);
        @(negedge clk_100MHz);
        check("post_rst_idle", running, 0);
        check("total_en", en_q.size(), 14);
        check("total_clr", clr_q.size(), 1);
        check("total_hb", n_hb, 14);
        check("strobe_width", n_wide, 0);

        // From IDLE, a step gives one pulse and lands in PAUSE
        goto(r0 + 450);
        press(3'b010);
        goto(r0 + 470);
        @(negedge clk_100MHz);
        check("idle_step_pulse", en_between(r0 + 450, r0 + 470), 1);
        check("idle_step_cycle", first_en_after(r0 + 450), r0 + 458);
        check("idle_step_norun", running, 0);
        check("idle_step_hb", heartbeat, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
